matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Upstream control stage of the 4x4 matrix multiplier.
- Computes C = A x B one element at a time. Operands are read from the shared 9-bit-addressed operand RAM; each result is written back to the C region of the same RAM.
- When all 16 results are written, raises a one-cycle `EnableListo` pulse that sets the done-flag register (mapped at 9'h184).
- Started by the bus master through `Start`.

Parameters:
- DATA_W, 8, operand element width in bits.
- ACC_W, 18, accumulator/result width; must be at least 2*DATA_W+2.
- A_BASE, 9'h000, word address of A[0][0]; element A[i][k] is at A_BASE + 4*i + k.
- B_BASE, 9'h040, word address of B[0][0]; element B[k][j] is at B_BASE + 4*k + j.
- C_BASE, 9'h080, word address of C[0][0]; element C[i][j] is at C_BASE + 4*i + j.

Ports:
- CLK  in  1  single clock, rising edge.
- ResetMaster  in  1  synchronous, active-high reset.
- Start  in  1  level; sampled only in IDLE.
- RdEn  out  1  operand read strobe.
- RdAddr  out  9  operand read address.
- RdData  in  DATA_W  operand data; valid exactly one cycle after RdEn.
- WrEn  out  1  result write strobe.
- WrAddr  out  9  result write address.
- WrData  out  ACC_W  result data.
- Busy  out  1  high in every state except IDLE.
- EnableListo  out  1  one-cycle done pulse.

Behaviour:
- Reset: state=IDLE, i=j=k=0, acc=0, a_q=0. All outputs 0. Addresses and data read 0.
- Output timing: all outputs decode from registered state and counters (Moore). There is no combinational input-to-output path.
- State IDLE:
  - Start=1 -> RD_A; clear i, j, k and acc.
  - Start=0 -> stay in IDLE.
- State RD_A: RdEn=1, RdAddr=A_BASE+4i+k. Next state RD_B.
- State RD_B: RdEn=1, RdAddr=B_BASE+4k+j; a_q<=RdData (the A element). Next state MAC.
- State MAC: acc<=acc+a_q*RdData (the B element), zero-extended to ACC_W.
  - k==3 -> WRITE, k<=0.
  - Otherwise k<=k+1 -> RD_A.
- State WRITE: WrEn=1, WrAddr=C_BASE+4i+j, WrData=acc. On exit acc<=0.
  - Advance j; when j wraps 3->0, advance i.
  - i==3 and j==3 -> DONE; otherwise -> RD_A.
- State DONE: EnableListo=1 for exactly one cycle; then IDLE.
- Latency:
  - 13 cycles per element, 208 for the full matrix.
  - EnableListo is high in the 209th cycle after the edge that samples Start.
  - Busy is high for 209 cycles.
- Ordering: C is produced in row-major order, exactly 16 writes per run, never two writes to the same address.
- Arithmetic:
  - Default is unsigned.
  - Worst case 4*255*255=260100, which fits 18 bits, so no overflow with defaults.
- Start held high through DONE: a new run begins on the IDLE cycle that follows. Start pulses during Busy are ignored, not queued.
- ResetMaster mid-run: on the next edge return to IDLE, outputs 0, no further writes. Partially written C contents remain in RAM.
- Reset has priority over every other event, including Start in the same cycle.

Optional Feature:
- Macro: MATMUL_SIGNED_EN.
- Defined: operands are two's complement. Products are sign-extended to ACC_W before accumulation, and WrData is a signed ACC_W value. Range check: -128*-128*4 = 65536, which fits 18-bit signed.
- Undefined: unsigned zero-extension as above.
- Timing, addressing and handshake are identical in both builds.

Decomposition:
- Package matmul_pkg:
  - state encoding (IDLE, RD_A, RD_B, MAC, WRITE, DONE);
  - DIM=4;
  - default A_BASE/B_BASE/C_BASE;
  - LISTO_ADDR=9'h184, for reference by the decoder and checked by the bench for non-overlap with A/B/C.
- Sub-module matmul_mac:
  - holds the acc register and the multiplier;
  - inputs: clr, en, a, b;
  - output: acc;
  - the signed/unsigned macro is confined to this sub-module.

Test Plan:
- Identity and ramp: A=identity, B[k][j]=4k+j, Start pulse -> 16 writes in row-major order, C[i][j]=4i+j at addresses 9'h080..9'h08F, EnableListo once.
- Saturation-free max: all A and B elements = 255 -> every WrData = 260100; EnableListo at cycle 209; Busy high for 209 cycles.
- Address sequence: first 12 cycles of RdAddr = 000,040,–,001,044,–,002,048,–,003,04C,– (– = no read, RdEn=0); first WrAddr=080 at cycle 13.
- Start re-assertion: extra Start pulses at cycles 5 and 100 -> no effect; exactly 16 writes, one EnableListo.
- Reset mid-run: ResetMaster at cycle 60 -> next cycle Busy=0, WrEn=0, RdEn=0. A fresh Start then yields a correct full C.
- With MATMUL_SIGNED_EN: A=B=all 8'h80 (-128) -> every WrData = 65536. A all -1, B all 2 -> every WrData = -8 (18'h3FFF8).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the 4x4 matrix-multiply sequencer: state encoding,
// matrix dimension, default RAM region bases and the done-flag address.
// Optional build macro MATMUL_SIGNED_EN is consumed by matmul_mac only.
package matmul_pkg;

  localparam int unsigned DIM    = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ADDR_W = 9;

  localparam logic [ADDR_W-1:0] A_BASE_DEF = 9'h000;
  localparam logic [ADDR_W-1:0] B_BASE_DEF = 9'h040;
  localparam logic [ADDR_W-1:0] C_BASE_DEF = 9'h080;
  localparam logic [ADDR_W-1:0] LISTO_ADDR = 9'h184;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    WRITE,
    DONE
  } state_e;

  // Row-major element address: base + DIM*row + col (DIM is a power of two).
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  row,
                                                  input logic [IDX_W-1:0]  col);
    return base + ADDR_W'({row, col});
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate datapath for one C element.
// Ports: clk_i/rst_i (sync active-high), clr_i zeroes acc, en_i adds a_i*b_i,
//        acc_o is the running sum.
// Macro MATMUL_SIGNED_EN: defined -> two's-complement operands with the
// product sign-extended; undefined -> unsigned, zero-extended product.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = ACC_W - PROD_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_ext;

`ifdef MATMUL_SIGNED_EN
  logic signed [PROD_W-1:0] prod;
  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
`else
  logic [PROD_W-1:0] prod;
  assign prod     = a_i * b_i;
  assign prod_ext = {{EXT_W{1'b0}}, prod};
`endif

  // Clear wins over accumulate so a new element always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Control stage of the 4x4 matrix multiplier: computes C = A x B one element
// at a time from the shared operand RAM, writes each C element back, then
// pulses EnableListo to set the done flag.
// Ports: CLK, ResetMaster (sync active-high), Start (level, sampled in IDLE),
//        RdEn/RdAddr/RdData (read port, data one cycle after RdEn),
//        WrEn/WrAddr/WrData (result write), Busy, EnableListo.
// Outputs are Moore-decoded from registered state and counters.
// Macro MATMUL_SIGNED_EN selects signed arithmetic inside matmul_mac.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ACC_W  = 18,
  parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
  parameter logic [ADDR_W-1:0] B_BASE = B_BASE_DEF,
  parameter logic [ADDR_W-1:0] C_BASE = C_BASE_DEF
) (
  input  logic              CLK,
  input  logic              ResetMaster,
  input  logic              Start,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [ACC_W-1:0]  WrData,
  output logic              Busy,
  output logic              EnableListo
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic               mac_clr, mac_en;
  logic [ACC_W-1:0]   acc;

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk_i (CLK),
    .rst_i (ResetMaster),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_q),
    .b_i   (RdData),
    .acc_o (acc)
  );

  // Next-state, counter update and Moore output decode.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    a_d         = a_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    RdEn        = 1'b0;
    RdAddr      = '0;
    WrEn        = 1'b0;
    WrAddr      = '0;
    WrData      = '0;
    Busy        = 1'b1;
    EnableListo = 1'b0;

    unique case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          state_d = RD_A;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      RD_A: begin
        RdEn    = 1'b1;
        RdAddr  = elem_addr(A_BASE, i_q, k_q);
        state_d = RD_B;
      end
      RD_B: begin
        // RdData now carries the A element requested in RD_A.
        RdEn    = 1'b1;
        RdAddr  = elem_addr(B_BASE, k_q, j_q);
        a_d     = RdData;
        state_d = MAC;
      end
      MAC: begin
        // RdData now carries the B element requested in RD_B.
        mac_en = 1'b1;
        if (k_q == IDX_LAST) begin
          k_d     = '0;
          state_d = WRITE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = RD_A;
        end
      end
      WRITE: begin
        WrEn    = 1'b1;
        WrAddr  = elem_addr(C_BASE, i_q, j_q);
        WrData  = acc;
        mac_clr = 1'b1;
        j_d     = j_q + 2'd1;
        if (j_q == IDX_LAST) begin
          i_d = i_q + 2'd1;
        end
        if ((i_q == IDX_LAST) && (j_q == IDX_LAST)) begin
          state_d = DONE;
        end else begin
          state_d = RD_A;
        end
      end
      DONE: begin
        EnableListo = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ResetMaster) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a RAM model, a cycle-schedule reference model
// and per-cycle output comparison, plus literal end-of-run expectations.
// Honours MATMUL_SIGNED_EN for the arithmetic of the reference model.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ACC_W   = 18;
  localparam int          ELEM_CYC = 13;
  localparam int          RUN_CYC  = DIM * DIM * ELEM_CYC + 1;

  logic              CLK;
  logic              ResetMaster;
  logic              Start;
  logic              RdEn;
  logic [ADDR_W-1:0] RdAddr;
  logic [DATA_W-1:0] RdData;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [ACC_W-1:0]  WrData;
  logic              Busy;
  logic              EnableListo;

  matmul_sequencer dut (
    .CLK         (CLK),
    .ResetMaster (ResetMaster),
    .Start       (Start),
    .RdEn        (RdEn),
    .RdAddr      (RdAddr),
    .RdData      (RdData),
    .WrEn        (WrEn),
    .WrAddr      (WrAddr),
    .WrData      (WrData),
    .Busy        (Busy),
    .EnableListo (EnableListo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [ACC_W-1:0]  mem [512];
  logic [ACC_W-1:0]  exp_c [16];
  int                checks;
  int                errors;
  int                cyc;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_pend_addr;
  int                n_wr, n_listo, n_busy, listo_at;
  logic [ADDR_W-1:0] rd_trace [12];
  logic [ADDR_W-1:0] wr_trace13;
  bit                seen [16];

  function automatic int sval(input logic [DATA_W-1:0] v);
`ifdef MATMUL_SIGNED_EN
    return v[DATA_W-1] ? int'(v) - 256 : int'(v);
`else
    return int'(v);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, expv);
    end
  endtask

  // C = A x B with plain integer arithmetic, truncated to the result width.
  task automatic compute_exp();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s += sval(mem[A_BASE_DEF + 9'(4*r + k)][7:0]) *
               sval(mem[B_BASE_DEF + 9'(4*k + c)][7:0]);
        end
        exp_c[4*r + c] = 18'(s);
      end
    end
  endtask

  // One clock: advance the schedule model, serve the RAM, compare outputs.
  task automatic tick();
    logic              e_rd, e_wr, e_busy, e_listo;
    logic [ADDR_W-1:0] e_ra, e_wa;
    logic [ACC_W-1:0]  e_wd;
    int el, p, r, c, kk;

    @(posedge CLK);
    if (ResetMaster) begin
      cyc = 0;
    end else if (cyc == 0) begin
      if (Start) begin
        cyc = 1;
        compute_exp();
        n_wr = 0; n_listo = 0; n_busy = 0; listo_at = 0;
        wr_trace13 = 9'h1FF;
        for (int n = 0; n < 16; n++) seen[n] = 1'b0;
        for (int n = 0; n < 12; n++) rd_trace[n] = 9'h1FF;
      end
    end else if (cyc == RUN_CYC) begin
      cyc = 0;
    end else begin
      cyc++;
    end
    #1;
    RdData = rd_pend ? mem[rd_pend_addr][7:0] : 8'($urandom);

    @(negedge CLK);
    e_rd = 0; e_wr = 0; e_busy = 0; e_listo = 0;
    e_ra = '0; e_wa = '0; e_wd = '0;
    if (cyc != 0) begin
      e_busy = 1;
      if (cyc == RUN_CYC) begin
        e_listo = 1;
      end else begin
        el = (cyc - 1) / ELEM_CYC;
        p  = (cyc - 1) % ELEM_CYC;
        r  = el / 4;
        c  = el % 4;
        if (p == 12) begin
          e_wr = 1;
          e_wa = C_BASE_DEF + 9'(el);
          e_wd = exp_c[el];
        end else begin
          kk = p / 3;
          if (p % 3 == 0) begin
            e_rd = 1;
            e_ra = A_BASE_DEF + 9'(4*r + kk);
          end else if (p % 3 == 1) begin
            e_rd = 1;
            e_ra = B_BASE_DEF + 9'(4*kk + c);
          end
        end
      end
    end
    chk("RdEn",        32'(RdEn),        32'(e_rd));
    chk("RdAddr",      32'(RdAddr),      32'(e_ra));
    chk("WrEn",        32'(WrEn),        32'(e_wr));
    chk("WrAddr",      32'(WrAddr),      32'(e_wa));
    chk("WrData",      32'(WrData),      32'(e_wd));
    chk("Busy",        32'(Busy),        32'(e_busy));
    chk("EnableListo", 32'(EnableListo), 32'(e_listo));

    if (cyc >= 1 && cyc <= 12) rd_trace[cyc-1] = RdEn ? RdAddr : 9'h1FF;
    if (cyc == 13) wr_trace13 = WrEn ? WrAddr : 9'h1FF;
    if (Busy) n_busy++;
    if (EnableListo) begin
      n_listo++;
      listo_at = cyc;
    end
    rd_pend      = RdEn;
    rd_pend_addr = RdAddr;
    if (WrEn) begin
      if (WrAddr >= C_BASE_DEF && WrAddr < C_BASE_DEF + 9'd16) begin
        chk("wr_unique", 32'(seen[WrAddr[3:0]]), 32'd0);
        seen[WrAddr[3:0]] = 1'b1;
      end
      mem[WrAddr] = WrData;
      n_wr++;
    end
  endtask

  task automatic clear_c();
    for (int n = 0; n < 16; n++) mem[C_BASE_DEF + 9'(n)] = '0;
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] bv);
    for (int n = 0; n < 16; n++) begin
      mem[A_BASE_DEF + 9'(n)] = 18'(av);
      mem[B_BASE_DEF + 9'(n)] = 18'(bv);
    end
    clear_c();
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 16; n++) begin
      mem[A_BASE_DEF + 9'(n)] = 18'($urandom_range(0, 255));
      mem[B_BASE_DEF + 9'(n)] = 18'($urandom_range(0, 255));
    end
    clear_c();
  endtask

  // Start one run; optional extra Start pulses and a mid-run reset (0 = none).
  task automatic do_run(input int pulse1, input int pulse2, input int rst_at);
    Start = 1'b1;
    tick();
    for (int c = 1; c <= RUN_CYC + 2; c++) begin
      Start       = (c == pulse1 || c == pulse2);
      ResetMaster = (c == rst_at);
      tick();
    end
    Start       = 1'b0;
    ResetMaster = 1'b0;
  endtask

  task automatic end_checks();
    chk("write_count", 32'(n_wr),     32'd16);
    chk("listo_count", 32'(n_listo),  32'd1);
    chk("listo_cycle", 32'(listo_at), 32'd209);
    chk("busy_cycles", 32'(n_busy),   32'd209);
    for (int n = 0; n < 16; n++) begin
      chk("c_in_ram", 32'(mem[C_BASE_DEF + 9'(n)]), 32'(exp_c[n]));
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] lit_rd [12];
    lit_rd = '{9'h000, 9'h040, 9'h1FF, 9'h001, 9'h044, 9'h1FF,
               9'h002, 9'h048, 9'h1FF, 9'h003, 9'h04C, 9'h1FF};
    checks = 0; errors = 0; cyc = 0;
    rd_pend = 1'b0; rd_pend_addr = '0;
    n_wr = 0; n_listo = 0; n_busy = 0; listo_at = 0; wr_trace13 = '0;
    for (int n = 0; n < 512; n++) mem[n] = '0;
    for (int n = 0; n < 16; n++) begin seen[n] = 1'b0; exp_c[n] = '0; end
    for (int n = 0; n < 12; n++) rd_trace[n] = '0;
    RdData = '0;

    // Reset, including Start asserted alongside reset.
    ResetMaster = 1'b1;
    Start       = 1'b0;
    tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    ResetMaster = 1'b0;
    tick();
    tick();

    // Identity x ramp: C[i][j] = 4i+j.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mem[A_BASE_DEF + 9'(4*r + c)] = (r == c) ? 18'd1 : 18'd0;
        mem[B_BASE_DEF + 9'(4*r + c)] = 18'(4*r + c);
      end
    end
    clear_c();
    do_run(0, 0, 0);
    end_checks();
    for (int n = 0; n < 16; n++) chk("ident_ramp_lit", 32'(mem[9'h080 + 9'(n)]), 32'(n));
    for (int n = 0; n < 12; n++) chk("rd_addr_seq", 32'(rd_trace[n]), 32'(lit_rd[n]));
    chk("first_wr_addr", 32'(wr_trace13), 32'h080);

`ifdef MATMUL_SIGNED_EN
    fill_const(8'h80, 8'h80);
    do_run(0, 0, 0);
    end_checks();
    for (int n = 0; n < 16; n++) chk("neg128_sq_lit", 32'(mem[9'h080 + 9'(n)]), 32'd65536);
    fill_const(8'hFF, 8'h02);
    do_run(0, 0, 0);
    end_checks();
    for (int n = 0; n < 16; n++) chk("neg8_lit", 32'(mem[9'h080 + 9'(n)]), 32'h3FFF8);
`else
    fill_const(8'hFF, 8'hFF);
    do_run(0, 0, 0);
    end_checks();
    for (int n = 0; n < 16; n++) chk("max_lit", 32'(mem[9'h080 + 9'(n)]), 32'd260100);
`endif

    // Start pulses while busy are ignored.
    fill_rand();
    do_run(5, 100, 0);
    end_checks();

    // Reset mid-run: partial C stays, then a fresh run completes.
    fill_rand();
    do_run(0, 0, 60);
    chk("rst_write_count", 32'(n_wr),    32'd4);
    chk("rst_listo_count", 32'(n_listo), 32'd0);
    for (int n = 0; n < 4; n++) chk("rst_partial_c", 32'(mem[C_BASE_DEF + 9'(n)]), 32'(exp_c[n]));
    chk("rst_unwritten_c", 32'(mem[C_BASE_DEF + 9'd4]), 32'd0);
    fill_rand();
    do_run(0, 0, 0);
    end_checks();

    // Start held high through DONE: second run begins on the following IDLE cycle.
    fill_rand();
    Start = 1'b1;
    for (int t = 0; t < RUN_CYC + 2; t++) tick();
    Start = 1'b0;
    for (int t = 0; t < RUN_CYC + 4; t++) tick();
    end_checks();

    // A few more random matrices.
    for (int rep = 0; rep < 3; rep++) begin
      fill_rand();
      do_run(0, 0, 0);
      end_checks();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
